uart_cmd_dispatch: RTL and testbench

Command sequencer between the UART command wrapper and a 64-entry register bus. Consumes each 24-bit command (8-bit cmd + 16-bit data) the wrapper assembles. Executes a write, read, ping or reject on the register bus with an ack timeout. Returns one or two response bytes through the wrapper's transmit handshake.

---
 rtl/uart_cmd_dispatch.sv | 176 +++++++++++++++++
 tb/tb_uart_cmd_dispatch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_dispatch.sv
// Command sequencer between the UART command wrapper and a 64-entry register bus.
// Runs write/read/ping/reject with an ack timeout and returns one or two response bytes.
module uart_cmd_dispatch #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [7:0]  ACK_BYTE = 8'hA5,
  parameter logic [7:0]  NAK_BYTE = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_rdy,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        clr_cmd_rdy,
  output logic        snd_resp,
  output logic [7:0]  resp,
  input  logic        resp_sent,
  output logic [5:0]  bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_wr,
  output logic        bus_rd,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ack,
  output logic        busy,
  output logic [7:0]  timeout_cnt
);

  typedef enum logic [2:0] {IDLE, DECODE, BUS, SEND, WAIT_TX} state_t;
  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_PING    = 2'b10,
    OP_INVALID = 2'b11
  } opcode_t;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  state_t      state, state_d;
  opcode_t     op;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  rdata_lo, rdata_lo_d;
  logic        hi_pending, hi_pending_d;
  logic [15:0] wait_cnt, wait_cnt_d;
  logic        resp_sent_q;
  logic        clr_d, snd_d, bus_wr_d, bus_rd_d, busy_d;
  logic [7:0]  resp_d, timeout_cnt_d;
  logic [5:0]  bus_addr_d;
  logic [15:0] bus_wdata_d;

  assign op = opcode_t'(cmd_q[7:6]);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state;
    cmd_d         = cmd_q;
    data_d        = data_q;
    rdata_lo_d    = rdata_lo;
    hi_pending_d  = hi_pending;
    wait_cnt_d    = wait_cnt;
    resp_d        = resp;
    bus_addr_d    = bus_addr;
    bus_wdata_d   = bus_wdata;
    timeout_cnt_d = timeout_cnt;
    clr_d         = 1'b0;
    snd_d         = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_rdy) begin
          cmd_d   = cmd;
          data_d  = data;
          clr_d   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (op)
          OP_WRITE, OP_READ: begin
            bus_addr_d  = cmd_q[5:0];
            bus_wdata_d = data_q;
            wait_cnt_d  = '0;
            state_d     = BUS;
          end
          OP_PING: begin
            resp_d  = ACK_BYTE;
            state_d = SEND;
          end
          default: begin
            resp_d  = NAK_BYTE;
            state_d = SEND;
          end
        endcase
      end
      BUS: begin
        // An ack on the final wait cycle still wins over the timeout.
        if (bus_ack) begin
          if (op == OP_WRITE) begin
            resp_d = ACK_BYTE;
          end else begin
            resp_d       = bus_rdata[15:8];
            rdata_lo_d   = bus_rdata[7:0];
            hi_pending_d = 1'b1;
          end
          state_d = SEND;
        end else if (wait_cnt == LAST_WAIT) begin
          resp_d = NAK_BYTE;
          if (timeout_cnt != 8'hFF) timeout_cnt_d = timeout_cnt + 8'd1;
          state_d = SEND;
        end else begin
          wait_cnt_d = wait_cnt + 16'd1;
        end
      end
      SEND: begin
        snd_d   = 1'b1;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        // Only a fresh rising edge counts; a level left high from the last byte does not.
        if (resp_sent && !resp_sent_q) begin
          if (hi_pending) begin
            hi_pending_d = 1'b0;
            resp_d       = rdata_lo;
            state_d      = SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    bus_wr_d = (state_d == BUS) && (op == OP_WRITE);
    bus_rd_d = (state_d == BUS) && (op == OP_READ);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_q       <= '0;
      data_q      <= '0;
      rdata_lo    <= '0;
      hi_pending  <= 1'b0;
      wait_cnt    <= '0;
      resp_sent_q <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      snd_resp    <= 1'b0;
      resp        <= '0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wr      <= 1'b0;
      bus_rd      <= 1'b0;
      busy        <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state       <= state_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      rdata_lo    <= rdata_lo_d;
      hi_pending  <= hi_pending_d;
      wait_cnt    <= wait_cnt_d;
      resp_sent_q <= resp_sent;
      clr_cmd_rdy <= clr_d;
      snd_resp    <= snd_d;
      resp        <= resp_d;
      bus_addr    <= bus_addr_d;
      bus_wdata   <= bus_wdata_d;
      bus_wr      <= bus_wr_d;
      bus_rd      <= bus_rd_d;
      busy        <= busy_d;
      timeout_cnt <= timeout_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Randomized bench for uart_cmd_dispatch: a transaction-level model predicts bus
// cycles, response bytes, timing and the timeout count for every command.
module tb_uart_cmd_dispatch;

  localparam int TO = 8;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy, snd_resp;
  logic [7:0]  resp;
  logic        resp_sent;
  logic [5:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_wr, bus_rd;
  logic [15:0] bus_rdata;
  logic        bus_ack;
  logic        busy;
  logic [7:0]  timeout_cnt;

  int checks = 0;
  int failures = 0;
  int m_tcnt = 0;
  bit hold_stale = 1'b0;

  uart_cmd_dispatch #(.TIMEOUT(TO), .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
    .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .clr_cmd_rdy(clr_cmd_rdy), .snd_resp(snd_resp), .resp(resp), .resp_sent(resp_sent),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one command from the wrapper side; optionally raises the next command mid-flight.
  task automatic run_txn(input logic [7:0] c, input logic [15:0] d, input int ack_dly,
                         input logic [15:0] rd, input bit nxt, input logic [7:0] nc,
                         input logic [15:0] nd);
    logic [7:0] q[$];
    logic [1:0] op;
    logic [7:0] cur_resp;
    int exp_req, exp_bytes, n, cyc, req, last_req, last_rise, rises, tx_wait;
    bit first, rose, done, tx_active, bad_kind, bad_bus, bad_clr, bad_stable, extra;

    op = c[7:6];
    exp_req = 0;
    case (op)
      2'b00, 2'b01: begin
        if (ack_dly < TO) begin
          exp_req = ack_dly + 1;
          if (op == 2'b00) q.push_back(ACK);
          else begin q.push_back(rd[15:8]); q.push_back(rd[7:0]); end
        end else begin
          exp_req = TO;
          q.push_back(NAK);
          if (m_tcnt < 255) m_tcnt++;
        end
      end
      2'b10:   q.push_back(ACK);
      default: q.push_back(NAK);
    endcase
    exp_bytes = q.size();

    cmd_rdy = 1'b1; cmd = c; data = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!clr_cmd_rdy && n < 50);
    check("clr_seen", clr_cmd_rdy, 1);
    check("clr_latency", n, 1);
    cmd_rdy = 1'b0; cmd = 8'($urandom); data = 16'($urandom);

    cyc = 0; req = 0; last_req = -1; last_rise = -1; rises = 0; tx_wait = 0; cur_resp = '0;
    first = 1'b1; rose = 1'b0; done = 1'b0; tx_active = 1'b0;
    bad_kind = 1'b0; bad_bus = 1'b0; bad_clr = 1'b0; bad_stable = 1'b0; extra = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus_ack = 1'b0;
      if (clr_cmd_rdy) bad_clr = 1'b1;
      if (bus_wr && bus_rd) bad_kind = 1'b1;
      if (bus_wr || bus_rd) begin
        req++;
        last_req = cyc;
        if (bus_wr != (op == 2'b00)) bad_kind = 1'b1;
        if (bus_addr != c[5:0]) bad_bus = 1'b1;
        if (bus_wr && bus_wdata != d) bad_bus = 1'b1;
        if (req == ack_dly + 1) begin bus_ack = 1'b1; bus_rdata = rd; end
        else bus_rdata = 16'($urandom);
      end else if (busy && $urandom_range(0, 5) == 0) begin
        bus_ack = 1'b1;
        bus_rdata = 16'($urandom);
      end
      if (snd_resp) begin
        if (first) begin
          check("snd_latency", cyc, (exp_req > 0) ? last_req + 2 : 2);
          first = 1'b0;
        end else begin
          check("snd_after_rise", rose, 1);
        end
        rose = 1'b0;
        if (q.size() == 0) extra = 1'b1;
        else check("resp_byte", resp, q.pop_front());
      end
      if (!busy) begin
        done = 1'b1;
        check("busy_fall", cyc - last_rise, 1);
      end else begin
        if (nxt && cyc == 3) begin cmd_rdy = 1'b1; cmd = nc; data = nd; end
        if (snd_resp) begin
          tx_active = 1'b1;
          tx_wait = $urandom_range(1, 4);
          cur_resp = resp;
        end else if (tx_active) begin
          if (resp != cur_resp) bad_stable = 1'b1;
          if (tx_wait > 0) tx_wait--;
          else if (resp_sent) begin resp_sent = 1'b0; tx_wait = $urandom_range(0, 2); end
          else begin
            resp_sent = 1'b1; tx_active = 1'b0; rose = 1'b1; rises++; last_rise = cyc;
          end
        end else if (resp_sent && !hold_stale && $urandom_range(0, 3) == 0) begin
          resp_sent = 1'b0;
        end
      end
    end
    bus_ack = 1'b0;
    check("txn_done", done, 1);
    check("req_cycles", req, exp_req);
    check("bus_kind_ok", bad_kind, 0);
    check("bus_addr_data_ok", bad_bus, 0);
    check("no_clr_while_busy", bad_clr, 0);
    check("resp_stable", bad_stable, 0);
    check("resp_left", q.size(), 0);
    check("extra_resp", extra, 0);
    check("rises_used", rises, exp_bytes);
    check("timeout_cnt", timeout_cnt, m_tcnt);
  endtask

  initial begin
    logic [7:0]  c, nc;
    logic [15:0] d, nd;
    bit chained, nxt;
    int n;

    rst = 1'b1; cmd_rdy = 1'b0; cmd = '0; data = '0; resp_sent = 1'b0;
    bus_rdata = '0; bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {clr_cmd_rdy, snd_resp, resp, bus_addr, bus_wdata, bus_wr,
                            bus_rd, busy, timeout_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the block's intended use.
    run_txn(8'h05, 16'h1234, 2, 16'h0, 1'b0, 8'h0, 16'h0);
    hold_stale = 1'b1;
    run_txn(8'h4A, 16'h0, 1, 16'hBEEF, 1'b0, 8'h0, 16'h0);
    run_txn(8'h80, 16'h5555, 0, 16'h0, 1'b0, 8'h0, 16'h0);
    hold_stale = 1'b0;
    run_txn(8'hC3, 16'hAAAA, 0, 16'h0, 1'b0, 8'h0, 16'h0);
    run_txn(8'h11, 16'hCAFE, 20, 16'h0, 1'b0, 8'h0, 16'h0);
    run_txn(8'h12, 16'hF00D, TO - 1, 16'h0, 1'b0, 8'h0, 16'h0);
    run_txn(8'h3F, 16'h8001, 0, 16'h0, 1'b1, 8'h80, 16'h0);
    run_txn(8'h80, 16'h0, 0, 16'h0, 1'b0, 8'h0, 16'h0);

    // Drive the timeout counter into saturation.
    for (int i = 0; i < 258; i++)
      run_txn({1'b0, 1'(i), 6'(i)}, 16'(i), TO + 1, 16'h0, 1'b0, 8'h0, 16'h0);

    // Randomized traffic, including chained commands and stale resp_sent levels.
    chained = 1'b0; nc = '0; nd = '0;
    for (int i = 0; i < 120; i++) begin
      c = chained ? nc : 8'($urandom);
      d = chained ? nd : 16'($urandom);
      nc = 8'($urandom); nd = 16'($urandom);
      nxt = ($urandom_range(0, 3) == 0);
      if (!chained) repeat ($urandom_range(0, 2)) @(negedge clk);
      hold_stale = 1'($urandom_range(0, 1));
      run_txn(c, d, $urandom_range(0, 10), 16'($urandom), nxt, nc, nd);
      chained = nxt;
    end
    hold_stale = 1'b0;

    // Reset in the middle of a read; a following write must still complete.
    resp_sent = 1'b0;
    cmd_rdy = 1'b1; cmd = 8'h4A; data = 16'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (!clr_cmd_rdy && n < 50);
    cmd_rdy = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_rd && n < 50);
    check("rst_bus_rd_seen", bus_rd, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_bus_reset_outputs", {clr_cmd_rdy, snd_resp, resp, bus_addr, bus_wdata, bus_wr,
                                    bus_rd, busy, timeout_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    m_tcnt = 0;
    run_txn(8'h05, 16'h1234, 3, 16'h0, 1'b0, 8'h0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
